// File: rtl/regfile_dump.sv
// Register-file debug dump: streams {index, data[31:0]} frames over a valid/ready byte port.
// Define REGDUMP_CHECKSUM_EN to append a trailing XOR checksum byte after the last frame.
module regfile_dump #(
  parameter int unsigned NUM_REGS = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        busy,
  output logic        done
);

`ifdef REGDUMP_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StAddr, StSend, StCsum, StDone} state_e;
`else
  typedef enum logic [2:0] {StIdle, StAddr, StSend, StDone} state_e;
`endif

  state_e      state_q, state_d;
  logic [4:0]  idx_q;
  logic [2:0]  cnt_q;
  logic [39:0] frame_q;
  logic [7:0]  frame_byte;
  logic        xfer;
  logic        last_reg;
  logic        last_byte;

  assign rd_addr   = idx_q;
  assign xfer      = byte_valid & byte_ready;
  assign last_reg  = (idx_q == 5'(NUM_REGS - 1));
  assign last_byte = (cnt_q == 3'd4);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StAddr;
      StAddr: state_d = StSend;
      StSend: begin
        if (xfer && last_byte) begin
          if (!last_reg) begin
            state_d = StAddr;
          end else begin
`ifdef REGDUMP_CHECKSUM_EN
            state_d = StCsum;
`else
            state_d = StDone;
`endif
          end
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      StCsum: if (xfer) state_d = StDone;
`endif
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Register data is sampled once, on the edge that leaves ADDR.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q   <= 5'd0;
      cnt_q   <= 3'd0;
      frame_q <= 40'd0;
    end else begin
      unique case (state_q)
        StIdle: if (start) idx_q <= 5'd0;
        StAddr: begin
          frame_q <= {3'b000, idx_q, rd_data};
          cnt_q   <= 3'd0;
        end
        StSend: begin
          if (xfer) begin
            cnt_q <= cnt_q + 3'd1;
            if (last_byte && !last_reg) idx_q <= idx_q + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef REGDUMP_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      csum_q <= 8'd0;
    end else if (state_q == StIdle && start) begin
      csum_q <= 8'd0;
    end else if (state_q == StSend && xfer) begin
      csum_q <= csum_q ^ frame_byte;
    end
  end
`endif

  always_comb begin
    frame_byte = 8'd0;
    unique case (cnt_q)
      3'd0:    frame_byte = frame_q[39:32];
      3'd1:    frame_byte = frame_q[31:24];
      3'd2:    frame_byte = frame_q[23:16];
      3'd3:    frame_byte = frame_q[15:8];
      3'd4:    frame_byte = frame_q[7:0];
      default: frame_byte = 8'd0;
    endcase
  end

  always_comb begin
    byte_out   = 8'd0;
    byte_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      StAddr: busy = 1'b1;
      StSend: begin
        busy       = 1'b1;
        byte_valid = 1'b1;
        byte_out   = frame_byte;
      end
`ifdef REGDUMP_CHECKSUM_EN
      StCsum: begin
        busy       = 1'b1;
        byte_valid = 1'b1;
        byte_out   = csum_q;
      end
`endif
      StDone: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: a 32-register instance and a 4-register instance.
module tb_regfile_dump;

`ifdef REGDUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        start4 = 1'b0;
  logic        byte_ready = 1'b1;
  logic        byte_ready4 = 1'b1;
  logic [4:0]  rd_addr, rd_addr4;
  logic [31:0] rd_data, rd_data4;
  logic [7:0]  byte_out, byte_out4;
  logic        byte_valid, byte_valid4;
  logic        busy, busy4, done, done4;

  logic [31:0] regs [32];
  logic [7:0]  exp_q [$];
  logic [7:0]  rx [$];
  logic [7:0]  rx4 [$];
  int          done_cnt, busy_cnt, done_edge, last_xfer;
  int          done4_cnt, busy4_cnt;
  int          edge_n = 0;
  int          checks = 0;
  int          errors = 0;

  assign rd_data  = regs[rd_addr];
  assign rd_data4 = regs[rd_addr4];

  regfile_dump #(.NUM_REGS(32)) dut (
    .clock(clock), .reset(reset), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .busy(busy), .done(done)
  );

  regfile_dump #(.NUM_REGS(4)) dut4 (
    .clock(clock), .reset(reset), .start(start4), .rd_addr(rd_addr4), .rd_data(rd_data4),
    .byte_out(byte_out4), .byte_valid(byte_valid4), .byte_ready(byte_ready4),
    .busy(busy4), .done(done4)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (byte_valid && byte_ready) begin
      rx.push_back(byte_out);
      last_xfer = edge_n;
    end
    if (done) begin
      done_cnt++;
      done_edge = edge_n;
    end
    if (busy) busy_cnt++;
    if (byte_valid4 && byte_ready4) rx4.push_back(byte_out4);
    if (done4) done4_cnt++;
    if (busy4) busy4_cnt++;
    edge_n++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rx.delete();
    rx4.delete();
    done_cnt  = 0;
    busy_cnt  = 0;
    done_edge = -1;
    last_xfer = -100;
    done4_cnt = 0;
    busy4_cnt = 0;
  endtask

  task automatic build_exp(input int n);
    logic [7:0] cs;
    cs = 8'd0;
    exp_q.delete();
    for (int r = 0; r < n; r++) begin
      exp_q.push_back(8'(r));
      exp_q.push_back(regs[r][31:24]);
      exp_q.push_back(regs[r][23:16]);
      exp_q.push_back(regs[r][15:8]);
      exp_q.push_back(regs[r][7:0]);
    end
    foreach (exp_q[i]) cs ^= exp_q[i];
    if (CS == 1) exp_q.push_back(cs);
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_len"}, 64'(rx.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
      if (rx[i] !== exp_q[i]) check($sformatf("%s_byte%0d", tag, i), 64'(rx[i]), 64'(exp_q[i]));
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 600 && done_cnt == 0; k++) @(negedge clock);
    check({tag, "_done_seen"}, 64'(done_cnt > 0), 64'd1);
    repeat (3) @(negedge clock);
  endtask

  initial begin
    foreach (regs[i]) regs[i] = 32'd0;
    regs[1] = 32'h1234_5678;
    clear_mon();

    // Reset held with start=1: everything stays at zero.
    reset = 1'b1;
    start = 1'b1;
    start4 = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("rst_outs", {rd_addr, byte_out, byte_valid, busy, done}, 64'd0);
      check("rst_outs4", {rd_addr4, byte_out4, byte_valid4, busy4, done4}, 64'd0);
    end
    reset = 1'b0;
    start = 1'b0;
    start4 = 1'b0;
    repeat (20) begin
      @(negedge clock);
      check("idle_after_rst", {byte_valid, busy, byte_valid4, busy4}, 64'd0);
    end

    // Full dump with byte_ready held high.
    clear_mon();
    build_exp(32);
    pulse_start();
    check("first_addr", {busy, byte_valid, rd_addr}, {1'b1, 1'b0, 5'd0});
    @(negedge clock);
    check("first_byte", {byte_valid, byte_out}, {1'b1, 8'h00});
    wait_done("full");
    check_stream("full");
    check("full_done_cnt", 64'(done_cnt), 64'd1);
    check("full_busy_cycles", 64'(busy_cnt), 64'(32 * 6 + CS));
    check("full_done_timing", 64'(done_edge), 64'(last_xfer + 1));
    if (CS == 1 && rx.size() == 161) check("full_csum", 64'(rx[160]), 64'h08);

    // Backpressure on register 1 byte 2, plus start pulses that must be ignored.
    clear_mon();
    pulse_start();
    for (int k = 0; k < 50 && !(byte_valid && rd_addr == 5'd1 && byte_out == 8'h34); k++)
      @(negedge clock);
    check("bp_reached", {byte_valid, rd_addr, byte_out}, {1'b1, 5'd1, 8'h34});
    byte_ready = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("bp_hold", {byte_valid, byte_out}, {1'b1, 8'h34});
    end
    byte_ready = 1'b1;
    for (int k = 0; k < 100 && !(byte_valid && rd_addr == 5'd5); k++) @(negedge clock);
    check("send5_reached", {byte_valid, rd_addr}, {1'b1, 5'd5});
    pulse_start();
    for (int k = 0; k < 600 && !done; k++) @(negedge clock);
    check("bp_done_seen", 64'(done), 64'd1);
    pulse_start();
    repeat (10) begin
      @(negedge clock);
      check("no_restart", {busy, byte_valid}, 64'd0);
    end
    check_stream("bp");
    check("bp_after_34", (rx.size() > 8) ? 64'(rx[8]) : 64'hdead, 64'h56);
    check("bp_done_cnt", 64'(done_cnt), 64'd1);
    check("bp_busy_cycles", 64'(busy_cnt), 64'(32 * 6 + 3 + CS));

    // Reset in the middle of register 10's frame.
    clear_mon();
    pulse_start();
    for (int k = 0; k < 200 && !(byte_valid && rd_addr == 5'd10); k++) @(negedge clock);
    check("send10_reached", {byte_valid, rd_addr}, {1'b1, 5'd10});
    reset = 1'b1;
    #1;
    check("midrst_outs", {rd_addr, byte_out, byte_valid, busy, done}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check("midrst_no_done", 64'(done_cnt), 64'd0);
    check("midrst_idle", {busy, byte_valid}, 64'd0);
    clear_mon();
    pulse_start();
    check("restart_addr", {busy, rd_addr}, {1'b1, 5'd0});
    @(negedge clock);
    check("restart_first", {byte_valid, byte_out}, {1'b1, 8'h00});
    wait_done("restart");
    check_stream("restart");

    // Four-register instance.
    clear_mon();
    build_exp(4);
    start4 = 1'b1;
    @(negedge clock);
    start4 = 1'b0;
    for (int k = 0; k < 100 && done4_cnt == 0; k++) @(negedge clock);
    repeat (3) @(negedge clock);
    check("n4_len", 64'(rx4.size()), 64'(20 + CS));
    for (int r = 0; r < 4; r++)
      check($sformatf("n4_idx%0d", r), (rx4.size() > 5 * r) ? 64'(rx4[5 * r]) : 64'hdead, 64'(r));
    check("n4_r1_b1", (rx4.size() > 6) ? 64'(rx4[6]) : 64'hdead, 64'h12);
    check("n4_done_cnt", 64'(done4_cnt), 64'd1);
    check("n4_busy_cycles", 64'(busy4_cnt), 64'(4 * 6 + CS));
    if (CS == 1 && rx4.size() == 21) check("n4_csum", 64'(rx4[20]), 64'h08);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
